// File: rtl/n64_controller_responder.sv
// N64 controller-side responder: receives host command bytes on an open-collector line and answers.
// Optional feature: define N64_RESP_STATUS_CMD_EN to answer status/reset commands 0x00 and 0xFF.
module n64_controller_responder #(
    parameter int CYCLES_PER_US = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    inout  wire         fab_pin,
    input  logic [31:0] button_data,
    output logic [7:0]  cmd_byte,
    output logic        cmd_valid,
    output logic        reset_cmd,
    output logic        rx_error,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RX_BIT     = 3'd1;
    localparam logic [2:0] ST_RX_STOP    = 3'd2;
    localparam logic [2:0] ST_TURNAROUND = 3'd3;
    localparam logic [2:0] ST_TX_LOW     = 3'd4;
    localparam logic [2:0] ST_TX_HIGH    = 3'd5;
    localparam logic [2:0] ST_TX_STOP    = 3'd6;
    localparam logic [2:0] ST_GUARD      = 3'd7;

    localparam logic [15:0] T1U = 16'(CYCLES_PER_US);
    localparam logic [15:0] T2U = 16'(2 * CYCLES_PER_US);
    localparam logic [15:0] T3U = 16'(3 * CYCLES_PER_US);
    localparam logic [15:0] T8U = 16'(8 * CYCLES_PER_US);

    logic        sync1_r, sync2_r, prev_r;
    logic        line_s, fall_s, rise_s;
    logic [2:0]  state_r, state_n;
    logic [15:0] cnt_r, cnt_n;
    logic [2:0]  bit_cnt_r, bit_cnt_n;
    logic        sampled_r, sampled_n;
    logic        stop_fell_r, stop_fell_n;
    logic [7:0]  rx_shift_r, rx_shift_n;
    logic [31:0] tx_shift_r, tx_shift_n;
    logic [5:0]  tx_cnt_r, tx_cnt_n;
    logic [5:0]  tx_len_r, tx_len_n;
    logic [7:0]  cmd_byte_r, cmd_byte_n;
    logic        cmd_valid_r, cmd_valid_n;
    logic        reset_cmd_r, reset_cmd_n;
    logic        rx_error_r, rx_error_n;
    logic        busy_r;
    logic        drive_r;
    logic [15:0] low_len_s, high_len_s;

    assign line_s     = sync2_r;
    assign fall_s     = prev_r & ~sync2_r;
    assign rise_s     = ~prev_r & sync2_r;
    assign low_len_s  = tx_shift_r[31] ? T1U : T3U;
    assign high_len_s = tx_shift_r[31] ? T3U : T1U;

    assign fab_pin   = drive_r ? 1'b0 : 1'bz;
    assign cmd_byte  = cmd_byte_r;
    assign cmd_valid = cmd_valid_r;
    assign reset_cmd = reset_cmd_r;
    assign rx_error  = rx_error_r;
    assign busy      = busy_r;

    // Line synchronizer; history clears low so no falling edge exists until the line has read high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= fab_pin;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Next-state and datapath decisions for receive, turnaround and transmit.
    always_comb begin
        state_n     = state_r;
        cnt_n       = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
        bit_cnt_n   = bit_cnt_r;
        sampled_n   = sampled_r;
        stop_fell_n = stop_fell_r;
        rx_shift_n  = rx_shift_r;
        tx_shift_n  = tx_shift_r;
        tx_cnt_n    = tx_cnt_r;
        tx_len_n    = tx_len_r;
        cmd_byte_n  = cmd_byte_r;
        cmd_valid_n = 1'b0;
        reset_cmd_n = 1'b0;
        rx_error_n  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n = 16'd0;
                if (fall_s) begin
                    state_n   = ST_RX_BIT;
                    bit_cnt_n = 3'd0;
                    sampled_n = 1'b0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RX_BIT: begin
                if (cnt_r > T8U) begin
                    rx_error_n = 1'b1;
                    state_n    = ST_IDLE;
                end else if (!sampled_r && (cnt_r == T2U)) begin
                    rx_shift_n = {rx_shift_r[6:0], line_s};
                    if (bit_cnt_r == 3'd7) begin
                        state_n     = ST_RX_STOP;
                        stop_fell_n = 1'b0;
                    end else begin
                        bit_cnt_n = bit_cnt_r + 3'd1;
                        sampled_n = 1'b1;
                    end
                end else if (sampled_r && fall_s) begin
                    cnt_n     = 16'd0;
                    sampled_n = 1'b0;
                end else begin
                    state_n = ST_RX_BIT;
                end
            end
            ST_RX_STOP: begin
                if (cnt_r > T8U) begin
                    rx_error_n = 1'b1;
                    state_n    = ST_IDLE;
                end else if (!stop_fell_r && fall_s) begin
                    stop_fell_n = 1'b1;
                    cnt_n       = 16'd0;
                end else if (stop_fell_r && rise_s) begin
                    cmd_byte_n  = rx_shift_r;
                    cmd_valid_n = 1'b1;
                    cnt_n       = 16'd0;
                    if (rx_shift_r == 8'h01) begin
                        state_n    = ST_TURNAROUND;
                        tx_shift_n = button_data;
                        tx_len_n   = 6'd32;
`ifdef N64_RESP_STATUS_CMD_EN
                    end else if ((rx_shift_r == 8'h00) || (rx_shift_r == 8'hFF)) begin
                        state_n     = ST_TURNAROUND;
                        tx_shift_n  = {24'h050002, 8'h00};
                        tx_len_n    = 6'd24;
                        reset_cmd_n = (rx_shift_r == 8'hFF);
`endif
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_RX_STOP;
                end
            end
            ST_TURNAROUND: begin
                if (cnt_r == T2U - 16'd1) begin
                    state_n  = ST_TX_LOW;
                    cnt_n    = 16'd0;
                    tx_cnt_n = 6'd0;
                end else begin
                    state_n = ST_TURNAROUND;
                end
            end
            ST_TX_LOW: begin
                if (cnt_r == low_len_s - 16'd1) begin
                    state_n = ST_TX_HIGH;
                    cnt_n   = 16'd0;
                end else begin
                    state_n = ST_TX_LOW;
                end
            end
            ST_TX_HIGH: begin
                if (cnt_r == high_len_s - 16'd1) begin
                    cnt_n      = 16'd0;
                    tx_shift_n = {tx_shift_r[30:0], 1'b0};
                    if (tx_cnt_r == tx_len_r - 6'd1) begin
                        state_n = ST_TX_STOP;
                    end else begin
                        tx_cnt_n = tx_cnt_r + 6'd1;
                        state_n  = ST_TX_LOW;
                    end
                end else begin
                    state_n = ST_TX_HIGH;
                end
            end
            ST_TX_STOP: begin
                if (cnt_r == T2U - 16'd1) begin
                    state_n = ST_GUARD;
                    cnt_n   = 16'd0;
                end else begin
                    state_n = ST_TX_STOP;
                end
            end
            ST_GUARD: begin
                if (cnt_r == T2U - 16'd1) begin
                    state_n = ST_IDLE;
                    cnt_n   = 16'd0;
                end else begin
                    state_n = ST_GUARD;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 16'd0;
            end
        endcase
    end

    // State, datapath and registered outputs; the pin drive clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            bit_cnt_r   <= 3'd0;
            sampled_r   <= 1'b0;
            stop_fell_r <= 1'b0;
            rx_shift_r  <= 8'h00;
            tx_shift_r  <= 32'h0000_0000;
            tx_cnt_r    <= 6'd0;
            tx_len_r    <= 6'd0;
            cmd_byte_r  <= 8'h00;
            cmd_valid_r <= 1'b0;
            reset_cmd_r <= 1'b0;
            rx_error_r  <= 1'b0;
            busy_r      <= 1'b0;
            drive_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            bit_cnt_r   <= bit_cnt_n;
            sampled_r   <= sampled_n;
            stop_fell_r <= stop_fell_n;
            rx_shift_r  <= rx_shift_n;
            tx_shift_r  <= tx_shift_n;
            tx_cnt_r    <= tx_cnt_n;
            tx_len_r    <= tx_len_n;
            cmd_byte_r  <= cmd_byte_n;
            cmd_valid_r <= cmd_valid_n;
            reset_cmd_r <= reset_cmd_n;
            rx_error_r  <= rx_error_n;
            busy_r      <= (state_n != ST_IDLE);
            drive_r     <= (state_n == ST_TX_LOW) || (state_n == ST_TX_STOP);
        end
    end

endmodule
